// File: rtl/lsu_bridge.sv
// ---------------------------------------------------------------------------
// lsu_bridge : CPU load/store unit to memory-mapped device bus bridge
// Optional bus watchdog enabled with macro LSU_TIMEOUT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_bridge #(
  parameter logic [31:0] DM_BYTES   = 32'h3000,
  parameter int          TIMER_NUM  = 2,
  parameter logic [31:0] TIMER_BASE = 32'h7f00,
  parameter logic [31:0] INT_BASE   = 32'h7f20,
  parameter int          TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 load,
  input  logic                 store,
  input  logic                 if_byte,
  input  logic                 if_half,
  input  logic                 load_extend,
  input  logic [31:0]          address,
  input  logic [31:0]          wdata,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [31:0]          rdata,
  output logic                 adel,
  output logic                 ades,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [TIMER_NUM+1:0] bus_sel,
  output logic [31:0]          bus_addr,
  output logic [31:0]          bus_wdata,
  output logic [3:0]           bus_byteen,
  input  logic                 bus_ack,
  input  logic [31:0]          bus_rdata
);

  localparam int SW = TIMER_NUM + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic                 r_load, r_store, r_byte, r_half, r_ext;
  logic                 w_accept, w_fault, w_timeout, w_bus_done;
  logic                 w_is_byte, w_is_half, w_is_word, w_is_store, w_io;
  logic                 w_in_dm, w_in_int;
  logic [TIMER_NUM-1:0] w_in_tmr, w_tmr_cnt;
  logic [SW-1:0]        w_sel;
  logic [3:0]           w_byteen;
  logic [7:0]           w_lane_b;
  logic [15:0]          w_lane_h;
  logic [31:0]          w_ldata;

  // Address decode; DM wins over timers, timers win over INT if windows overlap
  assign w_in_dm  = address < DM_BYTES;
  assign w_in_int = (address >= INT_BASE) && (address < INT_BASE + 32'd4);

  for (genvar k = 0; k < TIMER_NUM; k++) begin : g_timer
    localparam logic [31:0] T_BASE = TIMER_BASE + 32'(16 * k);
    assign w_in_tmr[k]  = (address >= T_BASE) && (address < T_BASE + 32'd12);
    assign w_tmr_cnt[k] = (address >= T_BASE + 32'd8) && (address < T_BASE + 32'd12);
    assign w_sel[k+1]   = w_in_tmr[k] && !w_in_dm;
  end

  assign w_sel[0]    = w_in_dm;
  assign w_sel[SW-1] = w_in_int && !w_in_dm && (w_in_tmr == '0);

  assign w_is_byte  = if_byte;
  assign w_is_half  = if_half && !if_byte;
  assign w_is_word  = !if_byte && !if_half;
  assign w_is_store = store && !load;
  assign w_io       = |w_sel[SW-1:1];

  assign w_fault = (w_is_word && (address[1:0] != 2'b00)) ||
                   (w_is_half && address[0]) ||
                   (w_sel == '0) ||
                   (w_io && !w_is_word) ||
                   (w_is_store && |(w_tmr_cnt & w_sel[TIMER_NUM:1]));

  assign w_accept = (r_state == IDLE) && req_valid && (load || store);

  always_comb begin
    w_byteen = 4'b0000;
    if (w_is_store) begin
      if (w_is_byte)      w_byteen = 4'b0001 << address[1:0];
      else if (w_is_half) w_byteen = 4'b0011 << address[1:0];
      else                w_byteen = 4'b1111;
    end
  end

  always_comb begin
    w_lane_b = bus_rdata[7:0];
    w_lane_h = bus_rdata[15:0];
    case (bus_addr[1:0])
      2'd1: begin w_lane_b = bus_rdata[15:8];  w_lane_h = bus_rdata[23:8];           end
      2'd2: begin w_lane_b = bus_rdata[23:16]; w_lane_h = bus_rdata[31:16];          end
      2'd3: begin w_lane_b = bus_rdata[31:24]; w_lane_h = {8'h00, bus_rdata[31:24]}; end
      default: ;
    endcase
  end

  always_comb begin
    w_ldata = bus_rdata;
    if (r_byte)      w_ldata = {{24{r_ext && w_lane_b[7]}}, w_lane_b};
    else if (r_half) w_ldata = {{16{r_ext && w_lane_h[15]}}, w_lane_h};
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait;

  always_ff @(posedge clk) begin
    if (reset || (r_state != BUS)) r_wait <= '0;
    else if (!bus_ack)             r_wait <= r_wait + 1'b1;
  end

  // Fires in the TIMEOUT-th BUS cycle without ack; a same-cycle ack takes precedence
  assign w_timeout = (r_state == BUS) && !bus_ack && (r_wait == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_bus_done = (r_state == BUS) && (bus_ack || w_timeout);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_fault ? RESP : BUS;
      BUS:     if (bus_ack || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load     <= 1'b0;
      r_store    <= 1'b0;
      r_byte     <= 1'b0;
      r_half     <= 1'b0;
      r_ext      <= 1'b0;
      resp_valid <= 1'b0;
      rdata      <= '0;
      adel       <= 1'b0;
      ades       <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_sel    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_byteen <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (w_accept) begin
        r_load     <= load;
        r_store    <= w_is_store;
        r_byte     <= w_is_byte;
        r_half     <= w_is_half;
        r_ext      <= load_extend;
        bus_addr   <= address;
        bus_sel    <= w_sel;
        bus_wdata  <= wdata << {address[1:0], 3'b000};
        bus_byteen <= w_byteen;
        bus_we     <= w_is_store && !w_fault;
        bus_req    <= !w_fault;
        if (w_fault) begin
          resp_valid <= 1'b1;
          adel       <= load;
          ades       <= w_is_store;
          rdata      <= '0;
        end
      end else if (w_bus_done) begin
        bus_req    <= 1'b0;
        resp_valid <= 1'b1;
        if (bus_ack) begin
          adel  <= 1'b0;
          ades  <= 1'b0;
          rdata <= r_load ? w_ldata : 32'h0;
        end else begin
          adel  <= r_load;
          ades  <= r_store;
          rdata <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire
